// File: rtl/mdm_pkg.sv
// mdm_pkg: shared types for the metadata adder scheduler
package mdm_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after the last grant
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);
  logic [IDW-1:0] w_idx;
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_idx   = '0;
    // descending scan so the nearest requester after i_last wins
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDW'((int'(i_last) + k) % NREQ);
      if (i_en && i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin shared sum/magnitude pipeline with credit-limited output FIFO
module adder_rr_sched import mdm_pkg::*; #(
  parameter  int NREQ      = 4,
  parameter  int WWIDTH    = 32,
  parameter  int OUT_DEPTH = 4,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ*WWIDTH-1:0]   i_req_mid,
  input  logic [NREQ*WWIDTH-1:0]   i_req_bits,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [IDW-1:0]           o_rsp_id,
  output logic [WWIDTH-1:0]        o_rsp_mag,
  output logic                     o_rsp_sign,
  output logic                     o_idle
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  sched_state_e      r_state, w_state_nxt;
  logic [IDW-1:0]    r_last, w_id;
  logic [CW-1:0]     r_out, w_out_nxt, r_cnt;
  logic              r_s1_v;
  logic [WWIDTH-1:0] r_s1_sum, w_sum, w_mag;
  logic [IDW-1:0]    r_s1_id;
  logic              w_sign, w_acc, w_pop, w_gnt_en;
  logic [WWIDTH-1:0] w_mid [NREQ];
  logic [WWIDTH-1:0] w_bits [NREQ];
  logic [WWIDTH-1:0] r_mag [OUT_DEPTH];
  logic              r_sign [OUT_DEPTH];
  logic [IDW-1:0]    r_id [OUT_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_mid[g]  = i_req_mid[g*WWIDTH +: WWIDTH];
    assign w_bits[g] = i_req_bits[g*WWIDTH +: WWIDTH];
  end

  // credits use the registered count only, so a pop never frees a slot in the same cycle
  assign w_gnt_en = (r_state == ACTIVE) && i_en && (r_out < CW'(OUT_DEPTH));

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .i_en    (w_gnt_en),
    .o_grant (o_req_ready),
    .o_id    (w_id)
  );

  assign w_acc       = |o_req_ready;
  assign o_rsp_valid = (r_cnt != '0);
  assign w_pop       = o_rsp_valid && i_rsp_ready;
  assign w_out_nxt   = r_out + CW'(w_acc) - CW'(w_pop);
  assign w_sum       = w_mid[w_id] + w_bits[w_id];
  assign w_sign      = r_s1_sum[WWIDTH-1];
  assign w_mag       = w_sign ? (~r_s1_sum + WWIDTH'(1)) : r_s1_sum;
  assign o_rsp_id    = o_rsp_valid ? r_id[r_rp]   : '0;
  assign o_rsp_mag   = o_rsp_valid ? r_mag[r_rp]  : '0;
  assign o_rsp_sign  = o_rsp_valid ? r_sign[r_rp] : 1'b0;
  assign o_idle      = (r_state == IDLE) && (r_out == '0);

  always_comb begin
    w_state_nxt = i_en ? ACTIVE :
                  (r_state == ACTIVE) ? DRAIN :
                  (r_state == DRAIN && w_out_nxt != '0) ? DRAIN : IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_last   <= IDW'(NREQ - 1);
      r_out    <= '0;
      r_s1_v   <= 1'b0;
      r_s1_sum <= '0;
      r_s1_id  <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_s1_v   <= w_acc;
      r_s1_sum <= w_sum;
      r_s1_id  <= w_id;
      r_cnt    <= r_cnt + CW'(r_s1_v) - CW'(w_pop);
      if (w_acc) r_last <= w_id;
      if (r_s1_v) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
    end
  end

  // second pipeline stage writes straight into the FIFO; storage needs no reset
  always_ff @(posedge i_clk) begin
    if (r_s1_v) begin
      r_mag[r_wp]  <= w_mag;
      r_sign[r_wp] <= w_sign;
      r_id[r_wp]   <= r_s1_id;
    end
  end
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: randomized scenarios checked against a queue-based reference model
module tb_adder_rr_sched;
  typedef struct packed {logic [1:0] id; logic [31:0] mag; logic sign;} rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_mid = '0;
  logic [127:0] req_bits = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_mag;
  logic         rsp_sign;
  logic         idle;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_last = 3;
  int m_out = 0;
  int acc_n = 0;
  int pop_n = 0;
  int bad_arb = 0;
  int acc_cyc = 0;
  int pop_cyc = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];
  int g_exp[$];
  int g_obs[$];

  adder_rr_sched dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_mid   (req_mid),
    .i_req_bits  (req_bits),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_mag   (rsp_mag),
    .o_rsp_sign  (rsp_sign),
    .o_idle      (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  // advance one cycle, recording handshakes and the model's view of them
  task automatic tick();
    int p;
    int o;
    longint s;
    logic [31:0] sum;
    rsp_t e;
    @(negedge clk);
    if ($countones(req_ready) > 1) bad_arb++;
    if (|req_ready) begin
      if (m_out >= 4) bad_arb++;
      p = rr_pick(req_valid, m_last);
      o = 0;
      for (int i = 0; i < 4; i++) if (req_ready[i]) o = i;
      g_exp.push_back(p);
      g_obs.push_back(o);
      if (p < 0) p = 0;
      sum = req_mid[p*32 +: 32] + req_bits[p*32 +: 32];
      s = longint'($signed(sum));
      e.id = 2'(p);
      e.sign = (s < 0);
      e.mag = 32'((s < 0) ? -s : s);
      exp_q.push_back(e);
      m_last = p;
      m_out++;
      acc_n++;
      acc_cyc = cyc;
    end
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_id, rsp_mag, rsp_sign});
      m_out--;
      pop_n++;
      pop_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear();
    exp_q.delete();
    got_q.delete();
    g_exp.delete();
    g_obs.delete();
    acc_n = 0;
    pop_n = 0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) begin
      req_mid[i*32 +: 32] = $urandom;
      req_bits[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && m_out > 0; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
    checks++; if (rsp_mag !== 32'd0) begin failures++; $display("FAIL reset_rsp_mag got=%h want=0", rsp_mag); end
    checks++; if (rsp_sign !== 1'b0) begin failures++; $display("FAIL reset_rsp_sign got=%b want=0", rsp_sign); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b want=1", idle); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input int r, input logic [31:0] mid, input logic [31:0] bits, output rsp_t got, output int lat);
    int start_pop;
    clear();
    en = 1'b1;
    rsp_ready = 1'b1;
    req_mid[r*32 +: 32] = mid;
    req_bits[r*32 +: 32] = bits;
    req_valid = 4'(1 << r);
    for (int i = 0; i < 8 && acc_n == 0; i++) tick();
    req_valid = '0;
    start_pop = pop_n;
    for (int i = 0; i < 10 && pop_n == start_pop; i++) tick();
    lat = pop_cyc - acc_cyc;
    got = (got_q.size() > 0) ? got_q[0] : '0;
    checks++; if (got_q.size() != 1 || got !== exp_q[0]) begin failures++; $display("FAIL single_model got=%h want=%h n=%0d", got, exp_q[0], got_q.size()); end
  endtask

  task automatic test_basic();
    rsp_t g;
    int lat;
    single_op(0, 32'd5, 32'd3, g, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
    checks++; if (g !== {2'd0, 32'd8, 1'b0}) begin failures++; $display("FAIL basic_result got=%h want id0 mag8 sign0", g); end
  endtask

  task automatic test_negative();
    rsp_t g;
    int lat;
    single_op(2, 32'd2, 32'hFFFF_FFF9, g, lat);
    checks++; if (g !== {2'd2, 32'd5, 1'b1}) begin failures++; $display("FAIL neg5_result got=%h want id2 mag5 sign1", g); end
    single_op(1, 32'h8000_0000, 32'd0, g, lat);
    checks++; if (g !== {2'd1, 32'h8000_0000, 1'b1}) begin failures++; $display("FAIL most_negative got=%h want id1 mag80000000 sign1", g); end
    for (int t = 0; t < 6; t++) begin
      single_op(int'($urandom_range(0, 3)), $urandom, $urandom, g, lat);
      checks++; if (lat != 2) begin failures++; $display("FAIL rand_latency got=%0d want=2", lat); end
    end
  endtask

  task automatic test_round_robin();
    int first;
    clear();
    en = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 20; i++) begin randomize_data(); tick(); end
    first = (acc_n > 0) ? acc_cyc - acc_n + 1 : 0;
    checks++; if (acc_n < 19) begin failures++; $display("FAIL rr_rate got=%0d want>=19", acc_n); end
    foreach (g_obs[k]) begin
      checks++; if (g_obs[k] !== g_exp[k]) begin failures++; $display("FAIL rr_pick idx=%0d got=%0d want=%0d", k, g_obs[k], g_exp[k]); end
      if (k > 0) begin checks++; if (g_obs[k] !== (g_obs[k-1] + 1) % 4) begin failures++; $display("FAIL rr_rotate idx=%0d got=%0d want=%0d", k, g_obs[k], (g_obs[k-1] + 1) % 4); end end
    end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (got_q[k]) if (k < exp_q.size()) begin checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL rr_rsp idx=%0d got=%h want=%h", k, got_q[k], exp_q[k]); end end
    checks++; if (bad_arb != 0) begin failures++; $display("FAIL rr_arb_rules got=%0d want=0 first=%0d", bad_arb, first); end
  endtask

  task automatic test_backpressure();
    rsp_t held;
    int a;
    clear();
    en = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin randomize_data(); tick(); end
    held = {rsp_id, rsp_mag, rsp_sign};
    checks++; if (acc_n != 4) begin failures++; $display("FAIL bp_accepts got=%0d want=4", acc_n); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b1 || held !== exp_q[0]) begin failures++; $display("FAIL bp_head got=%h want=%h", held, exp_q[0]); end
    for (int i = 0; i < 3; i++) begin randomize_data(); tick(); end
    checks++; if ({rsp_id, rsp_mag, rsp_sign} !== held) begin failures++; $display("FAIL bp_hold got=%h want=%h", {rsp_id, rsp_mag, rsp_sign}, held); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    a = acc_n;
    checks++; if (pop_n != 1 || a != 4) begin failures++; $display("FAIL bp_one_pop pops=%0d accepts=%0d want 1 and 4", pop_n, a); end
    tick();
    checks++; if (acc_n != 5) begin failures++; $display("FAIL bp_regrant got=%0d want=5", acc_n); end
    tick();
    checks++; if (acc_n != 5) begin failures++; $display("FAIL bp_full_again got=%0d want=5", acc_n); end
    drain();
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL bp_count got=%0d want=5", got_q.size()); end
    foreach (got_q[k]) if (k < exp_q.size()) begin checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL bp_rsp idx=%0d got=%h want=%h", k, got_q[k], exp_q[k]); end end
  endtask

  task automatic test_drain();
    int a;
    clear();
    en = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    randomize_data();
    for (int i = 0; i < 8 && acc_n < 2; i++) tick();
    en = 1'b0;
    a = acc_n;
    for (int i = 0; i < 10 && pop_n < 2; i++) tick();
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL drain_idle got=%b want=1", idle); end
    checks++; if (acc_n != a || a != 2) begin failures++; $display("FAIL drain_no_grant got=%0d want=2", acc_n); end
    checks++; if (pop_n != 2) begin failures++; $display("FAIL drain_pops got=%0d want=2", pop_n); end
    foreach (got_q[k]) if (k < exp_q.size()) begin checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL drain_rsp idx=%0d got=%h want=%h", k, got_q[k], exp_q[k]); end end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (acc_n != 2 || req_ready !== 4'b0) begin failures++; $display("FAIL drain_stopped accepts=%0d ready=%b", acc_n, req_ready); end
  endtask

  task automatic test_reset_mid();
    clear();
    en = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    randomize_data();
    for (int i = 0; i < 8 && acc_n < 3; i++) tick();
    req_valid = '0;
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b want=1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", rsp_valid); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle got=%b want=1", idle); end
    clear();
    m_out = 0;
    m_last = 3;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    randomize_data();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (idle !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_release idle=%b valid=%b want 1 0", idle, rsp_valid); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8 && acc_n == 0; i++) tick();
    checks++; if (g_obs.size() == 0 || g_obs[0] !== 0) begin failures++; $display("FAIL rstmid_first_grant got=%0d want=0", (g_obs.size() > 0) ? g_obs[0] : -1); end
    for (int i = 0; i < 5; i++) begin randomize_data(); tick(); end
    drain();
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (got_q[k]) if (k < exp_q.size()) begin checks++; if (got_q[k] !== exp_q[k]) begin failures++; $display("FAIL rstmid_rsp idx=%0d got=%h want=%h", k, got_q[k], exp_q[k]); end end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
